// File: rtl/smart_scale_seq_if.sv
// Handshake/bus bundle for the smart_scale_seq BMI classifier.
// The master side is the load-cell sampler plus the report logic; the slave side is the classifier.
interface smart_scale_seq_if #(
    parameter int WW = 9,
    parameter int HW = 8
);
    logic          start;
    logic [HW-1:0] height;
    logic          sample_valid;
    logic [WW-1:0] weight;
    logic          busy;
    logic [9:0]    bmi10;
    logic          underweight;
    logic          normal_bmi;
    logic          overweight;
    logic          err;
    logic          result_valid;
    logic          result_ready;

    modport master (
        output start, height, sample_valid, weight, result_ready,
        input  busy, bmi10, underweight, normal_bmi, overweight, err, result_valid
    );

    modport slave (
        input  start, height, sample_valid, weight, result_ready,
        output busy, bmi10, underweight, normal_bmi, overweight, err, result_valid
    );
endinterface

// File: rtl/smart_scale_seq.sv
// Sequential BMI classifier. It waits for a stable window of weight samples and
// averages it. BMI x10 = avg*100000 / h^2 comes from a one-bit-per-cycle restoring
// divider. The result is classified and held on a valid/ready handshake.
module smart_scale_seq #(
    parameter int WW        = 9,
    parameter int HW        = 8,
    parameter int NAVG_LOG2 = 2,
    parameter int TOL       = 2,
    parameter int HMIN      = 50,
    parameter int UNDER_T   = 185,
    parameter int OVER_T    = 250
) (
    input  logic              clk,
    input  logic              rst_n,
    smart_scale_seq_if.slave  bus
);
    localparam int QW = WW + 17;           // dividend width: avg * 100000
    localparam int DW = 2 * HW;            // divisor width: h * h
    localparam int AW = WW + NAVG_LOG2;    // accumulator width, cannot overflow
    localparam int CW = NAVG_LOG2 + 1;     // window count width
    localparam int SW = $clog2(QW + 2);    // divide step counter width

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_DIVIDE  = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [QW-1:0] SCALE   = QW'(100000);
    localparam logic [HW-1:0] HMIN_V  = HW'(HMIN);
    localparam logic [WW-1:0] TOL_V   = WW'(TOL);
    localparam logic [9:0]    UNDER_V = 10'(UNDER_T);
    localparam logic [9:0]    OVER_V  = 10'(OVER_T);
    localparam logic [CW-1:0] WIN     = CW'(1 << NAVG_LOG2);
    localparam logic [SW-1:0] ST_LAST = SW'(QW);      // final divider iteration
    localparam logic [SW-1:0] ST_CLS  = SW'(QW + 1);  // classify step

    logic [1:0]    state_q;
    logic [HW-1:0] h_q;
    logic [WW-1:0] ref_q;
    logic [AW-1:0] sum_q;
    logic [CW-1:0] cnt_q;
    logic [SW-1:0] step_q;
    logic [QW-1:0] quo_q;
    logic [DW-1:0] rem_q;
    logic [DW-1:0] div_q;
    logic [9:0]    bmi_q;
    logic          under_q, normal_q, over_q, err_q, rv_q;

    // Window tracking: the deviation is measured against the window's first sample.
    logic [WW-1:0] diff;
    logic          in_tol;
    logic [WW-1:0] ref_nxt;
    logic [AW-1:0] sum_nxt;
    logic [CW-1:0] cnt_nxt;

    always_comb begin
        diff    = (bus.weight >= ref_q) ? (bus.weight - ref_q) : (ref_q - bus.weight);
        in_tol  = (cnt_q != '0) && (diff <= TOL_V);
        ref_nxt = ref_q;
        sum_nxt = AW'(bus.weight);
        cnt_nxt = CW'(1);
        if (in_tol) begin
            sum_nxt = sum_q + AW'(bus.weight);
            cnt_nxt = cnt_q + 1'b1;
        end else begin
            ref_nxt = bus.weight;
        end
    end

    // Divider operands and one restoring iteration: shift in the next dividend bit,
    // then subtract the divisor when it fits.
    logic [WW-1:0] avg;
    logic [QW-1:0] dividend;
    logic [DW-1:0] hsq;
    logic [DW:0]   rem_sh;
    logic          ge;
    logic [DW-1:0] rem_nxt;
    logic [9:0]    bmi_sat;

    always_comb begin
        avg      = WW'(sum_q >> NAVG_LOG2);
        dividend = QW'(avg) * SCALE;
        hsq      = DW'(h_q) * DW'(h_q);
        rem_sh   = {rem_q, quo_q[QW-1]};
        ge       = (rem_sh >= {1'b0, div_q});
        rem_nxt  = ge ? DW'(rem_sh - {1'b0, div_q}) : rem_sh[DW-1:0];
        bmi_sat  = (|quo_q[QW-1:10]) ? 10'd1023 : quo_q[9:0];
    end

    // Session FSM. Results land only at classify or on the height-error path,
    // so a reset mid-session can never leak a partial value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            h_q      <= '0;
            ref_q    <= '0;
            sum_q    <= '0;
            cnt_q    <= '0;
            step_q   <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            div_q    <= '0;
            bmi_q    <= '0;
            under_q  <= 1'b0;
            normal_q <= 1'b0;
            over_q   <= 1'b0;
            err_q    <= 1'b0;
            rv_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.height < HMIN_V) begin
                            bmi_q    <= '0;
                            under_q  <= 1'b0;
                            normal_q <= 1'b0;
                            over_q   <= 1'b0;
                            err_q    <= 1'b1;
                            rv_q     <= 1'b1;
                            state_q  <= S_DONE;
                        end else begin
                            h_q     <= bus.height;
                            sum_q   <= '0;
                            cnt_q   <= '0;
                            state_q <= S_COLLECT;
                        end
                    end
                end
                S_COLLECT: begin
                    if (bus.sample_valid) begin
                        ref_q <= ref_nxt;
                        sum_q <= sum_nxt;
                        cnt_q <= cnt_nxt;
                        if (cnt_nxt == WIN) begin
                            step_q  <= '0;
                            state_q <= S_DIVIDE;
                        end
                    end
                end
                S_DIVIDE: begin
                    if (step_q == '0) begin
                        quo_q  <= dividend;
                        rem_q  <= '0;
                        div_q  <= hsq;
                        step_q <= step_q + 1'b1;
                    end else if (step_q <= ST_LAST) begin
                        quo_q  <= {quo_q[QW-2:0], ge};
                        rem_q  <= rem_nxt;
                        step_q <= step_q + 1'b1;
                    end else if (step_q == ST_CLS) begin
                        bmi_q    <= bmi_sat;
                        under_q  <= (bmi_sat < UNDER_V);
                        over_q   <= (bmi_sat >= OVER_V);
                        normal_q <= (bmi_sat >= UNDER_V) && (bmi_sat < OVER_V);
                        err_q    <= 1'b0;
                        rv_q     <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.result_ready) begin
                        rv_q    <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy         = (state_q != S_IDLE);
    assign bus.bmi10        = bmi_q;
    assign bus.underweight  = under_q;
    assign bus.normal_bmi   = normal_q;
    assign bus.overweight   = over_q;
    assign bus.err          = err_q;
    assign bus.result_valid = rv_q;
endmodule
